// File: rtl/uart_frame_receiver.sv
// -----------------------------------------------------------------------------
// uart_frame_receiver
//
// Serial front end of the Arduino-to-elevator-controller link. Recovers 8N1
// frames from the asynchronous rx line using an oversampled bit clock and a
// 2-of-3 majority vote around the middle of each bit. It rejects false starts
// and flags framing errors. After a framing error (for example a line break)
// it does not accept another start bit until the line has been seen idle
// (high) again.
//
// Ports
//   clk        : system clock; all state changes on the rising edge
//   reset      : synchronous, active-low reset
//   rx         : asynchronous serial input, idle high
//   data       : last correctly received byte (LSB received first)
//   receiveAll : one-cycle strobe, data newly updated and valid
//   frameError : one-cycle strobe, stop bit sampled low, data unchanged
// -----------------------------------------------------------------------------
module uart_frame_receiver #(
    parameter int CLKFRQ     = 100000000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       receiveAll,
    output logic       frameError
);

    localparam int DIV  = CLKFRQ / (BAUDRATE * OVERSAMPLE);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TKW  = $clog2(OVERSAMPLE + 1);

    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'((DIV > 0) ? (DIV - 1) : 0);
    localparam logic [TKW-1:0]  TICK_S0   = TKW'(OVERSAMPLE / 2);
    localparam logic [TKW-1:0]  TICK_S1   = TKW'(OVERSAMPLE / 2 + 1);
    localparam logic [TKW-1:0]  TICK_S2   = TKW'(OVERSAMPLE / 2 + 2);
    localparam logic [TKW-1:0]  TICK_LAST = TKW'(OVERSAMPLE);

    generate
        if (DIV < 1) begin : gDivTooSmall
            $error("uart_frame_receiver: CLKFRQ too low for BAUDRATE*OVERSAMPLE (DIV < 1)");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : gBadOversample
            $error("uart_frame_receiver: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // 2-of-3 majority vote of the three mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic            rxMeta_r;
    logic            rxSync_r;
    logic            rx_s;
    logic [DIVW-1:0] cnt_r;
    logic            tick_s;
    logic            cntClear_s;

    state_t          state_r,      stateNext_s;
    logic [TKW-1:0]  tickIdx_r,    tickIdxNext_s;
    logic [TKW-1:0]  tickCount_s;
    logic [2:0]      bitIdx_r,     bitIdxNext_s;
    logic [1:0]      samp_r,       sampNext_s;
    logic [7:0]      shift_r,      shiftNext_s;
    logic [7:0]      data_r,       dataNext_s;
    logic            armed_r,      armedNext_s;
    logic            receiveAll_r, receiveAllNext_s;
    logic            frameError_r, frameErrorNext_s;
    logic            vote_s;

    assign rx_s        = rxSync_r;
    assign tick_s      = (cnt_r == DIV_LAST);
    assign tickCount_s = tickIdx_r + TKW'(1);
    // Third sample is the live line value on the deciding tick
    assign vote_s      = maj3(samp_r[0], samp_r[1], rx_s);

    // Two-flop synchronizer for the asynchronous rx line
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxMeta_r <= 1'b1;
            rxSync_r <= 1'b1;
        end else begin
            rxMeta_r <= rx;
            rxSync_r <= rxMeta_r;
        end
    end

    // Oversampling tick divider, realigned to the start edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (cntClear_s || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DIVW'(1);
        end
    end

    // FSM state and datapath register update
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            tickIdx_r    <= '0;
            bitIdx_r     <= 3'd0;
            samp_r       <= 2'b00;
            shift_r      <= 8'h00;
            data_r       <= 8'h00;
            armed_r      <= 1'b1;
            receiveAll_r <= 1'b0;
            frameError_r <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            tickIdx_r    <= tickIdxNext_s;
            bitIdx_r     <= bitIdxNext_s;
            samp_r       <= sampNext_s;
            shift_r      <= shiftNext_s;
            data_r       <= dataNext_s;
            armed_r      <= armedNext_s;
            receiveAll_r <= receiveAllNext_s;
            frameError_r <= frameErrorNext_s;
        end
    end

    // FSM next-state, sampling and strobe generation
    always_comb begin
        stateNext_s      = state_r;
        tickIdxNext_s    = tickIdx_r;
        bitIdxNext_s     = bitIdx_r;
        sampNext_s       = samp_r;
        shiftNext_s      = shift_r;
        dataNext_s       = data_r;
        armedNext_s      = armed_r;
        receiveAllNext_s = 1'b0;
        frameErrorNext_s = 1'b0;
        cntClear_s       = 1'b0;

        case (state_r)
            IDLE: begin
                tickIdxNext_s = '0;
                bitIdxNext_s  = 3'd0;
                if (!armed_r) begin
                    // After a framing error, wait for the line to go idle
                    if (rx_s) begin
                        armedNext_s = 1'b1;
                    end else begin
                        armedNext_s = 1'b0;
                    end
                end else if (!rx_s) begin
                    stateNext_s = START;
                    cntClear_s  = 1'b1;
                end else begin
                    stateNext_s = IDLE;
                end
            end

            START, DATA, STOP: begin
                if (tick_s) begin
                    tickIdxNext_s = (tickCount_s == TICK_LAST) ? TKW'(0) : tickCount_s;
                    if (tickCount_s == TICK_S0) begin
                        sampNext_s[0] = rx_s;
                    end else if (tickCount_s == TICK_S1) begin
                        sampNext_s[1] = rx_s;
                    end else begin
                        sampNext_s = samp_r;
                    end

                    case (state_r)
                        START: begin
                            if ((tickCount_s == TICK_S2) && vote_s) begin
                                // Line back high at mid start bit: false start
                                stateNext_s   = IDLE;
                                tickIdxNext_s = '0;
                            end else if (tickCount_s == TICK_LAST) begin
                                stateNext_s  = DATA;
                                bitIdxNext_s = 3'd0;
                            end else begin
                                stateNext_s = START;
                            end
                        end
                        DATA: begin
                            if (tickCount_s == TICK_S2) begin
                                shiftNext_s[bitIdx_r] = vote_s;
                            end else if (tickCount_s == TICK_LAST) begin
                                if (bitIdx_r == 3'd7) begin
                                    stateNext_s = STOP;
                                end else begin
                                    bitIdxNext_s = bitIdx_r + 3'd1;
                                end
                            end else begin
                                stateNext_s = DATA;
                            end
                        end
                        STOP: begin
                            // Leave at mid stop bit so a back-to-back start edge is caught
                            if (tickCount_s == TICK_S2) begin
                                stateNext_s   = IDLE;
                                tickIdxNext_s = '0;
                                if (vote_s) begin
                                    dataNext_s       = shift_r;
                                    receiveAllNext_s = 1'b1;
                                end else begin
                                    frameErrorNext_s = 1'b1;
                                    armedNext_s      = 1'b0;
                                end
                            end else begin
                                stateNext_s = STOP;
                            end
                        end
                        default: begin
                            stateNext_s = IDLE;
                        end
                    endcase
                end else begin
                    tickIdxNext_s = tickIdx_r;
                end
            end

            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    assign data       = data_r;
    assign receiveAll = receiveAll_r;
    assign frameError = frameError_r;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_receiver
//
// Directed bench for uart_frame_receiver at DIV=1 (one tick per clock, 16
// clocks per bit). Each frame sent pushes its expected strobe kind, data value
// and strobe cycle into a queue; a monitor pops and compares on every strobe.
// A strobe is expected 157 clocks after the start bit is driven: 2 clocks
// of synchronizer delay, then 154 ticks to the stop decision, then 1 clock
// for the output register.
// -----------------------------------------------------------------------------
module tb_uart_frame_receiver;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       receiveAll;
    logic       frameError;

    int         cycleCnt = 0;
    int         nAsserts = 0;
    int         nFails   = 0;
    logic [7:0] lastGood;

    typedef struct {
        logic       err;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t expQ[$];

    uart_frame_receiver #(
        .CLKFRQ(1600),
        .BAUDRATE(100),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .data(data),
        .receiveAll(receiveAll),
        .frameError(frameError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // Drive one frame; flipOff >= 0 inverts that sample offset in every bit
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int flipOff);
        logic [9:0] bits;
        exp_t       e;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int t = 0; t < 16; t++) begin
                @(negedge clk);
                if ((i == 0) && (t == 0)) begin
                    e.err = ~stopBit;
                    e.d   = stopBit ? b : lastGood;
                    e.cyc = cycleCnt + 157;
                    expQ.push_back(e);
                    if (stopBit) lastGood = b;
                end
                rx = (t == flipOff) ? ~bits[i] : bits[i];
            end
        end
    endtask

    initial begin
        logic [9:0] partial;
        exp_t       brk;

        rx       = 1'b1;
        reset    = 1'b0;
        lastGood = 8'h00;

        // Strobe monitor: every strobe must match the head of the queue
        fork
            forever begin
                @(negedge clk);
                if (receiveAll || frameError) begin
                    exp_t e;
                    check("exclusive", {31'd0, receiveAll & frameError}, 32'd0);
                    check("pending", {31'd0, expQ.size() > 0}, 32'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        check("kind", {31'd0, frameError}, {31'd0, e.err});
                        check("data", {24'd0, data}, {24'd0, e.d});
                        check("cycle", cycleCnt, e.cyc);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst data", {24'd0, data}, 32'd0);
        check("rst receiveAll", {31'd0, receiveAll}, 32'd0);
        check("rst frameError", {31'd0, frameError}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(20);

        // Valid byte
        sendFrame(8'hA5, 1'b1, -1);
        idle(20);
        check("after A5", {24'd0, data}, 32'h0000_00A5);

        // Framing error: data must keep A5
        sendFrame(8'h5A, 1'b0, -1);
        idle(20);
        check("after ferr", {24'd0, data}, 32'h0000_00A5);

        // Back-to-back frames
        for (int v = 0; v < 10; v++) begin
            sendFrame(8'(v), 1'b1, -1);
        end
        idle(20);

        // False start: 4 low ticks, then a good frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(40);
        sendFrame(8'h3C, 1'b1, -1);
        idle(20);

        // Break for 30 bit times, then re-arm and send 0x81
        @(negedge clk);
        brk.err = 1'b1;
        brk.d   = lastGood;
        brk.cyc = cycleCnt + 157;
        expQ.push_back(brk);
        rx = 1'b0;
        repeat (479) @(negedge clk);
        idle(40);
        sendFrame(8'h81, 1'b1, -1);
        idle(20);

        // One corrupted sample per bit is outvoted
        sendFrame(8'hC3, 1'b1, 9);
        idle(20);
        check("noisy C3", {24'd0, data}, 32'h0000_00C3);

        // Reset mid-frame: no strobe, data cleared
        partial = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 16; t++) begin
                @(negedge clk);
                rx = partial[i];
            end
        end
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        idle(200);
        check("data after reset", {24'd0, data}, 32'd0);
        lastGood = 8'h00;

        sendFrame(8'h7E, 1'b1, -1);
        idle(200);
        check("after 7E", {24'd0, data}, 32'h0000_007E);
        check("all strobes seen", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
